// File: rtl/fifo_out_ctrl_if.sv
// Request, status and register-file bus between the output FIFO controller and its neighbours.
interface fifo_out_ctrl_if;
    logic          wr_en;
    logic [31:0]   din;
    logic          rd_en;
    logic [31:0]   rf_en;
    logic [31:0]   rf_d;
    logic [1023:0] rf_q;
    logic [31:0]   dout;
    logic          full;
    logic          empty;
    logic [5:0]    data_count;
    logic          wr_ack;
    logic          wr_err;
    logic          rd_ack;
    logic          rd_err;

    modport master (
        output wr_en, din, rd_en, rf_q,
        input  rf_en, rf_d, dout, full, empty, data_count,
        input  wr_ack, wr_err, rd_ack, rd_err
    );

    modport slave (
        input  wr_en, din, rd_en, rf_q,
        output rf_en, rf_d, dout, full, empty, data_count,
        output wr_ack, wr_err, rd_ack, rd_err
    );
endinterface

// File: rtl/fifo_out_ctrl.sv
// Control and read path of the 32x32 output FIFO; the storage is an external register file.
// Define FIFO_OUT_DOUT_HOLD_EN to keep dout at the last popped value between pops.
module fifo_out_ctrl #(
    parameter int unsigned DEPTH = 32
) (
    input logic           clk,
    input logic           reset_n,
    fifo_out_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_MID   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [4:0]  wr_ptr, rd_ptr;
    logic [5:0]  count, count_next;
    logic        push_ok, pop_ok;
    logic [31:0] dout_q;
    logic        wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
    logic [31:0] head;

    assign head = bus.rf_q[{rd_ptr, 5'd0} +: 32];

    // Acceptance is gated by reset_n so rf_en stays 0 while reset is held.
    always_comb begin
        push_ok    = 1'b0;
        pop_ok     = 1'b0;
        count_next = count;
        state_next = state;
        if (reset_n) begin
            push_ok = bus.wr_en && ((state != S_FULL) || bus.rd_en);
            pop_ok  = bus.rd_en && (state != S_EMPTY);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + 6'd1;
            2'b01:   count_next = count - 6'd1;
            default: count_next = count;
        endcase
        if (count_next == '0)
            state_next = S_EMPTY;
        else if (count_next == 6'(DEPTH))
            state_next = S_FULL;
        else
            state_next = S_MID;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_EMPTY;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dout_q   <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            count    <= count_next;
            wr_ack_q <= push_ok;
            wr_err_q <= bus.wr_en && !push_ok;
            rd_ack_q <= pop_ok;
            rd_err_q <= bus.rd_en && !pop_ok;
            if (push_ok)
                wr_ptr <= wr_ptr + 5'd1;
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 5'd1;
                dout_q <= head;
            end else begin
`ifdef FIFO_OUT_DOUT_HOLD_EN
                dout_q <= dout_q;
`else
                dout_q <= '0;
`endif
            end
        end
    end

    assign bus.rf_en      = push_ok ? (32'd1 << wr_ptr) : '0;
    assign bus.rf_d       = bus.din;
    assign bus.dout       = dout_q;
    assign bus.empty      = (state == S_EMPTY);
    assign bus.full       = (state == S_FULL);
    assign bus.data_count = count;
    assign bus.wr_ack     = wr_ack_q;
    assign bus.wr_err     = wr_err_q;
    assign bus.rd_ack     = rd_ack_q;
    assign bus.rd_err     = rd_err_q;
endmodule

// File: tb/tb_fifo_out_ctrl.sv
// Bench for fifo_out_ctrl: fixed vectors, directed corner sequences and random traffic vs a queue model.
module tb_fifo_out_ctrl;
`ifdef FIFO_OUT_DOUT_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fifo_out_ctrl_if bus();

    fifo_out_ctrl #(.DEPTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Behavioural register file fed by the controller's write port.
    logic [31:0] mem [32];
    always @(posedge clk) begin
        for (int k = 0; k < 32; k++)
            if (bus.rf_en[k]) mem[k] <= bus.rf_d;
    end
    for (genvar g = 0; g < 32; g++) begin : g_rfq
        assign bus.rf_q[32*g +: 32] = mem[g];
    end

    int          checks = 0;
    int          failures = 0;
    logic [31:0] q[$];
    int unsigned wptr = 0;
    logic [31:0] last = '0;
    logic [31:0] seen_rf_en;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] d;
        bit          wr_ack;
        bit          wr_err;
        bit          rd_ack;
        bit          rd_err;
        logic [5:0]  count;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input bit wr, input bit rd, input logic [31:0] d);
        int unsigned sz;
        bit          pa, po;
        logic [31:0] edout;
        @(negedge clk);
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.din   = d;
        #1;
        sz = q.size();
        pa = wr && (sz < 32 || rd);
        po = rd && (sz > 0);
        seen_rf_en = bus.rf_en;
        chk("rf_en", bus.rf_en, pa ? (32'd1 << wptr) : 32'd0);
        chk("rf_d", bus.rf_d, d);
        @(posedge clk);
        #1;
        if (po) begin
            last  = q.pop_front();
            edout = last;
        end else begin
            edout = HOLD ? last : 32'd0;
        end
        if (pa) begin
            q.push_back(d);
            wptr = (wptr + 1) % 32;
        end
        chk("wr_ack", bus.wr_ack, pa);
        chk("wr_err", bus.wr_err, wr && !pa);
        chk("rd_ack", bus.rd_ack, po);
        chk("rd_err", bus.rd_err, rd && !po);
        chk("data_count", bus.data_count, q.size());
        chk("empty", bus.empty, q.size() == 0);
        chk("full", bus.full, q.size() == 32);
        chk("dout", bus.dout, edout);
    endtask

    task automatic check_reset_vals();
        chk("rst_rf_en", bus.rf_en, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_count", bus.data_count, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_acks", {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}, 0);
    endtask

    // Reset is asserted asynchronously between edges with a push request pending.
    task automatic do_reset();
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.din   = 32'hDEAD_BEEF;
        reset_n   = 1'b0;
        #1;
        check_reset_vals();
        q.delete();
        wptr = 0;
        last = '0;
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        reset_n   = 1'b1;
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        for (int k = 0; k < 32; k++) mem[k] = '0;

        vecs[0] = '{0, 1, 32'h0,         0, 0, 0, 1, 6'd0, 32'h0};
        vecs[1] = '{1, 0, 32'hAAAA_0001, 1, 0, 0, 0, 6'd1, 32'h0};
        vecs[2] = '{1, 0, 32'hAAAA_0002, 1, 0, 0, 0, 6'd2, 32'h0};
        vecs[3] = '{1, 1, 32'hAAAA_0003, 1, 0, 1, 0, 6'd2, 32'hAAAA_0001};
        vecs[4] = '{0, 1, 32'h0,         0, 0, 1, 0, 6'd1, 32'hAAAA_0002};
        vecs[5] = '{0, 0, 32'h0,         0, 0, 0, 0, 6'd1, HOLD ? 32'hAAAA_0002 : 32'h0};
        vecs[6] = '{0, 1, 32'h0,         0, 0, 1, 0, 6'd0, 32'hAAAA_0003};
        vecs[7] = '{1, 1, 32'hAAAA_0004, 1, 0, 0, 1, 6'd1, HOLD ? 32'hAAAA_0003 : 32'h0};
        vecs[8] = '{0, 1, 32'h0,         0, 0, 1, 0, 6'd0, 32'hAAAA_0004};

        #12;
        check_reset_vals();
        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].d);
            chk("tbl_wr_ack", bus.wr_ack, vecs[i].wr_ack);
            chk("tbl_wr_err", bus.wr_err, vecs[i].wr_err);
            chk("tbl_rd_ack", bus.rd_ack, vecs[i].rd_ack);
            chk("tbl_rd_err", bus.rd_err, vecs[i].rd_err);
            chk("tbl_count", bus.data_count, vecs[i].count);
            chk("tbl_dout", bus.dout, vecs[i].dout);
        end

        // Fill from a fresh reset so the write enable walks from bit 0.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(1, 0, 32'(i + 1));
            chk("walk_rf_en", seen_rf_en, 32'h1 << i);
        end
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.data_count, 32);
        step(1, 0, 32'h21);
        chk("over_wr_err", bus.wr_err, 1);
        chk("over_rf_en", seen_rf_en, 0);
        for (int i = 0; i < 32; i++) begin
            step(0, 1, 0);
            chk("drain_dout", bus.dout, 32'(i + 1));
        end
        chk("drain_empty", bus.empty, 1);

        for (int i = 0; i < 32; i++) step(1, 0, $urandom);
        step(1, 1, 32'h5555_AAAA);
        chk("full_both_count", bus.data_count, 32);
        chk("full_both_acks", {bus.wr_ack, bus.rd_ack}, 2'b11);
        for (int i = 0; i < 32; i++) step(0, 1, 0);
        step(1, 1, 32'h1234_5678);
        chk("empty_both_rd_err", bus.rd_err, 1);
        chk("empty_both_count", bus.data_count, 1);

        for (int i = 0; i < 4; i++) step(1, 0, $urandom);
        chk("pre_rst_count", bus.data_count, 5);
        do_reset();
        step(0, 1, 0);
        chk("post_rst_rd_err", bus.rd_err, 1);

        // Interleaved traffic that wraps both pointers while staying shallow.
        for (int i = 0; i < 40; i++) step(1, q.size() >= 6, 32'(1000 + i));
        while (q.size() > 0) step(0, 1, 0);
        chk("wrap_ptr", wptr, 8);

        for (int ph = 0; ph < 4; ph++) begin
            int unsigned pw, pr;
            pw = (ph % 2 == 0) ? 80 : 25;
            pr = (ph % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 150; i++)
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, $urandom);
        end
        step(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fifo_out_ctrl.md
# fifo_out_ctrl

Control and read-path stage of the 32-entry, 32-bit output FIFO of the factorial machine. Turns push/pop requests into a one-hot write enable and write data for the 32×32 output register file. Selects the head entry from the file's 32 outputs onto a registered read port. Tracks occupancy and reports per-request acknowledge/error status.

## Interface
- `DEPTH`, 32: number of entries; fixed, must match the register file.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `wr_en` input 1: push request, `din` valid.
- `din` input 32: push data.
- `rd_en` input 1: pop request.
- `rf_en` output 32: one-hot write enable to the register file (bit k = entry k).
- `rf_d` output 32: write data to the register file; equals `din`.
- `rf_q` input 1024: flattened register-file outputs, entry k at bits [32k+31:32k].
- `dout` output 32: popped data.
- `full` output 1: 32 entries held.
- `empty` output 1: 0 entries held.
- `data_count` output 6: occupancy, 0..32.
- `wr_ack` / `wr_err` output 1 each: previous-cycle push accepted / rejected.
- `rd_ack` / `rd_err` output 1 each: previous-cycle pop accepted / rejected.

## Operation
- State: `wr_ptr[4:0]`, `rd_ptr[4:0]`, `data_count[5:0]`, plus a 2-bit occupancy state machine: `S_EMPTY`, `S_MID`, `S_FULL`.
- Push accepted when `wr_en` and not `S_FULL`, or when `wr_en`, `rd_en` and `S_FULL` (read frees a slot in the same cycle).
- Pop accepted when `rd_en` and not `S_EMPTY`. When `S_EMPTY` with both asserted: push accepted, pop rejected (no same-cycle bypass).
- `rf_en` is combinational: `1 << wr_ptr` when the push is accepted, else 0. `rf_d = din` always.
- On an accepted push, `wr_ptr` increments mod 32 (31 → 0).
- On an accepted pop, `rd_ptr` increments mod 32 (31 → 0).
- An accepted pop also registers `rf_q[32*rd_ptr +: 32]` into `dout`.
- `data_count`: +1 on push only, −1 on pop only, unchanged on both or neither; never exceeds 32 or goes below 0.
- State transitions, from the next value of `data_count`: 0 → `S_EMPTY`, 32 → `S_FULL`, else `S_MID`. `empty`/`full` decode the state register.
- `wr_ack`/`wr_err`/`rd_ack`/`rd_err` are registered every cycle from the current request and acceptance; with no request, both of that pair are 0.
- Reset values: pointers 0, `data_count` 0, state `S_EMPTY`, `empty`=1, `full`=0, `dout`=0, all ack/err 0, `rf_en`=0.
- Reset asserted mid-operation clears everything immediately. Register-file contents are not cleared and are unreachable until rewritten.

## Timing
- Push: `rf_en` high in cycle N. The register file and `wr_ptr` update at edge N.
- Push status: `wr_ack`, `data_count` and `empty` reflect it in cycle N+1.
- Pop requested in cycle N: `dout` and `rd_ack` are valid in cycle N+1 (1-cycle latency).
- Written data is poppable no earlier than the cycle after its write edge.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- `FIFO_OUT_DOUT_HOLD_EN` defined: `dout` holds the last popped value in cycles without `rd_ack`.
- Not defined: `dout` returns to 0 in every cycle where `rd_ack` is 0, including after `rd_err`.

## Test plan
- Reset, then pop on empty → next cycle `rd_err`=1, `rd_ack`=0, `dout`=0, `empty`=1, `data_count`=0.
- Push 0x00000001..0x00000020 (32 pushes) → `rf_en` walks 0x1 → 0x80000000. Then `full`=1, `data_count`=32. A 33rd push → `wr_err`=1 and `rf_en` stays 0.
- Pop all 32 → `dout` sequence 0x1..0x20, each one cycle after its request. Then `empty`=1.
- Wrap-around: push 40 and pop 40 interleaved (count held ≤ 8) → pointers wrap 31 → 0, order preserved, no errors.
- Simultaneous push+pop: when full, both accepted and `data_count` stays 32; when empty, push accepted, `rd_err`=1 and `data_count` becomes 1.
- Assert `reset_n` low mid-burst with count 5 → all outputs at reset values immediately. After release, a pop gives `rd_err`. Check `dout` hold versus clear with the macro defined and undefined.
